// File: rtl/bram_stream_reader.sv
// Burst read master for a 1-cycle registered-read BRAM.
// Turns (addr, len) commands into a valid/ready word stream.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_ra,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;
    logic                  inflight_last;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wptr;
    logic                  rptr;
    logic [1:0]            count;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  issue;

    assign busy      = (state != IDLE);
    assign cmd_ready = !busy;
    assign accept    = cmd_valid && cmd_ready;

    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rptr];
    assign out_last  = fifo_last[rptr];

    assign push = inflight;
    assign pop  = out_valid && out_ready;

    // Issue only while buffered plus in-flight words, net of this
    // cycle's pop, leave a free FIFO slot for the returning read.
    assign issue = (state == RUN) &&
                   (({1'b0, count} + {2'b00, inflight}) <
                    (3'd2 + {2'b00, pop}));

    assign ram_re = issue;
    assign ram_ra = addr;

    // Burst control: command load, read issue and end-of-burst detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (cmd_len != '0)) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue && (remaining == LEN_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                addr          <= addr + ADDR_WIDTH'(1);
                remaining     <= remaining - LEN_WIDTH'(1);
                inflight      <= 1'b1;
                inflight_last <= (remaining == LEN_WIDTH'(1));
            end else begin
                inflight      <= 1'b0;
            end
        end
    end

    // Two-entry output FIFO capturing BRAM data one cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last <= '0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wptr] <= ram_rd;
                fifo_last[wptr] <= inflight_last;
                wptr            <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader against a behavioural BRAM.
// Expected beats are queued at command time and checked by a monitor.
module tb_bram_stream_reader;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int LW = AW + 1;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    bram_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .ram_ra   (ram_ra),
        .ram_re   (ram_re),
        .ram_rd   (ram_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: registered read, holds when re is low.
    logic [DW-1:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        ram_rd = '0;
    end
    always @(posedge clk) begin
        if (ram_re) ram_rd <= mem[ram_ra];
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q [$];
    int    ra_q [$];
    int    beat_cyc [$];
    int    checks = 0;
    int    errors = 0;
    int    beats = 0;
    int    ncyc = 0;
    int    m_occ = 0;
    int    m_inf = 0;
    bit    prev_stall = 0;
    bit    want_idle = 0;
    logic [DW-1:0] prev_data = '0;
    bit    bp_mode = 0;
    logic  ready_fix = 1'b1;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: scoreboard pops, credit model, stall stability.
    always @(negedge clk) begin
        int pop;
        beat_t e;
        ncyc++;
        if (!rst_n) begin
            m_occ      = 0;
            m_inf      = 0;
            prev_stall = 0;
            want_idle  = 0;
        end else begin
            pop = (out_valid && out_ready) ? 1 : 0;
            if (want_idle) begin
                chk("idle_after_last", {busy, cmd_ready}, 2'b01);
                want_idle = 0;
            end
            chk("valid_vs_model", out_valid, (m_occ != 0));
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (ram_re) begin
                checks++;
                if (m_occ + m_inf - pop >= 2) begin
                    errors++;
                    $display("FAIL credit occ %0d inf %0d pop %0d",
                             m_occ, m_inf, pop);
                end
                ra_q.push_back(int'(ram_ra));
            end
            if (pop != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got %0h expected none",
                             out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_last", out_last, e.l);
                end
                beats++;
                beat_cyc.push_back(ncyc);
                if (out_last) want_idle = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            m_occ      = m_occ + m_inf - pop;
            m_inf      = ram_re ? 1 : 0;
        end
    end

    // Consumer ready driver: fixed or random backpressure.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    task automatic send(int a, int l);
        beat_t e;
        int t = 0;
        while (!cmd_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout got 0 expected 1");
        end
        for (int i = 0; i < l; i++) begin
            e.d = DW'((a + i) % 64);
            e.l = (i == l - 1);
            exp_q.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(l);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout got pending %0d expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ram_re"}, ram_re, 0);
        chk({tag, "_ram_ra"}, ram_ra, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        int b0;
        int exp_ra [4];
        exp_ra = '{62, 63, 0, 1};
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        #1;
        chk_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst with latency check.
        send(4, 3);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
        chk("first_latency", n, 3);
        wait_done();

        // Address wrap.
        ra_q.delete();
        send(62, 4);
        wait_done();
        chk("wrap_issue_count", ra_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ra_q.size()) chk("wrap_ra", ra_q[i], exp_ra[i]);
        end

        // Random backpressure.
        bp_mode = 1;
        send(10, 8);
        wait_done();
        send(20, 20);
        wait_done();
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Zero-length then back-to-back single word.
        send(0, 0);
        chk("len0_busy", busy, 0);
        chk("len0_cmd_ready", cmd_ready, 1);
        chk("len0_out_valid", out_valid, 0);
        send(9, 1);
        wait_done();

        // Reset mid-burst.
        b0 = beats;
        send(30, 6);
        n = 0;
        while (beats < b0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_beats", (beats >= b0 + 2), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_valid", out_valid, 0);
        chk("post_reset_busy", busy, 0);
        send(0, 2);
        wait_done();

        // Full memory sweep at full throughput.
        s  = beat_cyc.size();
        b0 = beats;
        send(0, 64);
        wait_done();
        chk("full_beats", beats - b0, 64);
        if (beat_cyc.size() >= s + 64) begin
            chk("full_span", beat_cyc[s + 63] - beat_cyc[s], 63);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
